join_match_ctrl: RTL
====================

Name: join_match_ctrl

Overview:
- Parametrised matching-memory controller for the JOIN stage of the data-driven pipeline.
- For each incoming token it makes one decision per transfer:
  - fire and delete a waiting partner entry,
  - allocate a free entry and write the token, or
  - pass the token through when no matching is required.
- Owns the entry-valid register, occupancy count and full/empty status.
- Applies back-pressure to upstream when the memory is full.

Parameters:
- DEPTH, 64, number of matching-memory entries (2..256).
- AW, $clog2(DEPTH), entry address width (derived; not overridden).

Ports:
- CP  in  1  clock, rising edge.
- MR  in  1  master reset, asynchronous, active-low.
- IN_REQ  in  1  upstream token present.
- IN_MF  in  1  token requires matching (1) or bypasses (0).
- FIRE  in  DEPTH  per-entry key-compare hits from the CAM.
- FLUSH  in  1  synchronous clear of all entries.
- IN_ACK  out  DEPTH-independent 1  token accepted this cycle (combinational).
- EN  out  DEPTH  one-hot entry write enable (registered pulse).
- WR_E  out  1  write strobe (registered pulse).
- DEL  out  1  fire/delete strobe (registered pulse).
- PASS  out  1  bypass strobe (registered pulse).
- ADDR  out  AW  entry address of last write/fire.
- VALID  out  DEPTH  entry occupied flags.
- COUNT  out  AW+1  number of occupied entries.
- FULL  out  1  COUNT==DEPTH.
- EMPTY  out  1  COUNT==0.

Behaviour:
- Reset (MR low, async): VALID=0, COUNT=0, EMPTY=1, FULL=0, EN=0, WR_E=0, DEL=0, PASS=0, ADDR=0.
- Qualified hits: HIT = FIRE & VALID.
  - FIRE bits on invalid entries are ignored.
  - R_ADDR = lowest set index of HIT.
- Free-entry select: W_ADDR = lowest index with VALID==0.
- IN_ACK = IN_REQ & ~FLUSH & ~(IN_MF & ~|HIT & FULL).
- A transfer occurs at the rising CP edge when IN_REQ & IN_ACK.
- Outputs are registered, so all strobes appear one cycle after the transfer edge and last exactly one cycle. With no transfer, strobes return to 0 and ADDR holds.
- Per transfer, in priority order:
  1. IN_MF=0: PASS=1. WR_E, DEL and EN stay 0. ADDR, VALID and COUNT hold.
  2. IN_MF=1 and |HIT: DEL=1, ADDR=R_ADDR, VALID[R_ADDR] cleared, COUNT-1. Fire wins over allocation even when free entries exist.
  3. IN_MF=1, no hit, ~FULL: WR_E=1, EN=1<<W_ADDR, ADDR=W_ADDR, VALID[W_ADDR] set, COUNT+1.
  4. IN_MF=1, no hit, FULL: no transfer. IN_ACK=0, upstream holds the token and all state holds. The token retries every cycle until an entry frees or a hit appears.
- FLUSH (sampled at edge) beats any transfer:
  - VALID=0, COUNT=0, strobes 0, ADDR holds.
  - IN_ACK=0 in the FLUSH cycle.
- VALID updates are visible from the next cycle.
  - An entry written at edge n can fire a token accepted at edge n+1.
  - An entry deleted at edge n is re-allocatable at edge n+1.
- COUNT never wraps: increment only when ~FULL, decrement only on a valid hit.
- FULL and EMPTY are derived from the registered COUNT.
- Entry indices wrap naturally: allocation is always lowest-free, not round-robin.
- Reset asserted mid-operation clears everything immediately, regardless of CP.

Test Plan:
- Reset, then DEPTH=4 with 4 transfers of IN_MF=1, FIRE=0 -> EN=0001,0010,0100,1000 on successive cycles; ADDR=0..3, WR_E pulses; COUNT=4, FULL=1.
- Full memory, IN_REQ=1, IN_MF=1, FIRE=0 for 3 cycles -> IN_ACK=0, no strobes, COUNT stays 4. Then FIRE=0100 -> IN_ACK=1; next cycle DEL=1, ADDR=2, VALID=1011, COUNT=3.
- VALID=0110, FIRE=1110 -> HIT=0110, DEL, ADDR=1 (lowest valid hit). FIRE bit 3 is ignored.
- IN_MF=0 token while FULL -> IN_ACK=1, PASS=1 for one cycle; ADDR, VALID and COUNT unchanged.
- Write to entry 0 at edge n, then FIRE=0001 token at edge n+1 -> DEL=1, ADDR=0, COUNT returns to prior value.
- FLUSH with IN_REQ=1 at COUNT=3 -> IN_ACK=0, next cycle VALID=0, COUNT=0, EMPTY=1. Asserting MR low mid-burst clears all outputs asynchronously.

Source files
------------

// File: rtl/join_match_ctrl.sv
// JOIN-stage matching-memory controller: per-token fire, allocate or bypass
// decision, plus entry-valid bookkeeping and occupancy status.
module join_match_ctrl #(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             CP,
    input  logic             MR,
    input  logic             IN_REQ,
    input  logic             IN_MF,
    input  logic [DEPTH-1:0] FIRE,
    input  logic             FLUSH,
    output logic             IN_ACK,
    output logic [DEPTH-1:0] EN,
    output logic             WR_E,
    output logic             DEL,
    output logic             PASS,
    output logic [AW-1:0]    ADDR,
    output logic [DEPTH-1:0] VALID,
    output logic [AW:0]      COUNT,
    output logic             FULL,
    output logic             EMPTY
);

    localparam logic [AW:0]      CNT_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0]      CNT_ONE = (AW+1)'(1);
    localparam logic [DEPTH-1:0] ONE_HOT = DEPTH'(1);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW:0]      count_q, count_d;
    logic [DEPTH-1:0] en_q, en_d;
    logic             wr_q, wr_d;
    logic             del_q, del_d;
    logic             pass_q, pass_d;
    logic [AW-1:0]    addr_q, addr_d;

    logic [DEPTH-1:0] hit;
    logic             any_hit;
    logic             full;
    logic             xfer;
    logic [AW-1:0]    r_addr;
    logic [AW-1:0]    w_addr;

    // Descending scan leaves the lowest matching index as the final value.
    always_comb begin
        hit    = FIRE & valid_q;
        r_addr = '0;
        w_addr = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hit[i])      r_addr = AW'(i);
            if (!valid_q[i]) w_addr = AW'(i);
        end
    end

    assign any_hit = |hit;
    assign full    = (count_q == CNT_MAX);
    assign IN_ACK  = IN_REQ & ~FLUSH & ~(IN_MF & ~any_hit & full);
    assign xfer    = IN_REQ & IN_ACK;

    always_comb begin
        valid_d = valid_q;
        count_d = count_q;
        addr_d  = addr_q;
        en_d    = '0;
        wr_d    = 1'b0;
        del_d   = 1'b0;
        pass_d  = 1'b0;
        if (FLUSH) begin
            valid_d = '0;
            count_d = '0;
        end else if (xfer) begin
            if (!IN_MF) begin
                pass_d = 1'b1;
            end else if (any_hit) begin
                del_d           = 1'b1;
                addr_d          = r_addr;
                valid_d[r_addr] = 1'b0;
                count_d         = count_q - CNT_ONE;
            end else begin
                wr_d            = 1'b1;
                en_d            = ONE_HOT << w_addr;
                addr_d          = w_addr;
                valid_d[w_addr] = 1'b1;
                count_d         = count_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge CP or negedge MR) begin
        if (!MR) begin
            valid_q <= '0;
            count_q <= '0;
            en_q    <= '0;
            wr_q    <= 1'b0;
            del_q   <= 1'b0;
            pass_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            en_q    <= en_d;
            wr_q    <= wr_d;
            del_q   <= del_d;
            pass_q  <= pass_d;
            addr_q  <= addr_d;
        end
    end

    assign EN    = en_q;
    assign WR_E  = wr_q;
    assign DEL   = del_q;
    assign PASS  = pass_q;
    assign ADDR  = addr_q;
    assign VALID = valid_q;
    assign COUNT = count_q;
    assign FULL  = full;
    assign EMPTY = (count_q == '0);

endmodule
